set_assoc_cache: RTL and testbench

Parametrised N-way set-associative, write-through, no-write-allocate data cache between the MEM pipeline stage and the SRAM controller. It generalises our 2-way cache to configurable ways, sets and tag width, and adds true-LRU replacement, write-hit update instead of invalidation, and an explicit miss/write FSM with a held SRAM handshake. Read hits complete combinationally; misses and writes stall the pipeline through `freeze`.

---
 rtl/set_assoc_cache.sv | 227 ++++++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative, write-through, no-write-allocate
// data cache with true-LRU replacement. Read hits complete combinationally;
// read misses and all stores go through a small FSM with a held SRAM handshake.
module set_assoc_cache #(
    parameter int WAYS     = 2,
    parameter int SET_BITS = 6,
    parameter int TAG_BITS = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        freeze,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        SRAM_mem_read,
    output logic        SRAM_mem_write,
    input  logic        sram_ready,
    input  logic [63:0] sram_rdata
);

    localparam int SETS     = 1 << SET_BITS;
    localparam int AGE_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WAY_BITS = AGE_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t state;

    logic [SETS-1:0]     valid    [WAYS];
    logic [AGE_BITS-1:0] age      [WAYS][SETS];
    logic [TAG_BITS-1:0] tag_mem  [WAYS][SETS];
    logic [63:0]         data_mem [WAYS][SETS];

    // Incoming request fields (looked up in IDLE)
    logic [SET_BITS-1:0] cur_idx;
    logic [TAG_BITS-1:0] cur_tag;
    logic                cur_word;
    // Registered request fields (used while waiting on SRAM)
    logic [SET_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0] req_tag;
    logic                req_word;

    assign cur_word = address[0];
    assign cur_idx  = address[SET_BITS:1];
    assign cur_tag  = address[SET_BITS+TAG_BITS:SET_BITS+1];
    assign req_word = sram_address[0];
    assign req_idx  = sram_address[SET_BITS:1];
    assign req_tag  = sram_address[SET_BITS+TAG_BITS:SET_BITS+1];

    logic                hit;
    logic [WAY_BITS-1:0] hit_way;
    logic [WAY_BITS-1:0] victim;
    logic                victim_found;
    logic [63:0]         hit_line;

    logic                touch_en;
    logic [WAY_BITS-1:0] touch_way;
    logic [SET_BITS-1:0] touch_idx;
    logic                fill_en;
    logic                store_hit;

    // Tag compare across all ways of the addressed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid[w][cur_idx] && (tag_mem[w][cur_idx] == cur_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
        hit_line = data_mem[hit_way][cur_idx];
    end

    // Victim for the pending fill: lowest invalid way, else the oldest way
    always_comb begin
        victim_found = 1'b0;
        victim       = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!victim_found && !valid[w][req_idx]) begin
                victim_found = 1'b1;
                victim       = WAY_BITS'(w);
            end
        end
        if (!victim_found) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age[w][req_idx] == AGE_BITS'(WAYS - 1)) begin
                    victim = WAY_BITS'(w);
                end
            end
        end
    end

    // Completion, read data and cache-update strobes for the current cycle
    always_comb begin
        ready     = 1'b0;
        rdata     = '0;
        touch_en  = 1'b0;
        touch_way = hit_way;
        touch_idx = cur_idx;
        fill_en   = 1'b0;
        store_hit = 1'b0;
        case (state)
            IDLE: begin
                if (MEM_R_EN) begin
                    if (hit) begin
                        ready    = 1'b1;
                        rdata    = cur_word ? hit_line[63:32] : hit_line[31:0];
                        touch_en = 1'b1;
                    end
                end else if (MEM_W_EN && hit) begin
                    touch_en  = 1'b1;
                    store_hit = 1'b1;
                end
            end
            RD_WAIT: begin
                if (sram_ready) begin
                    ready     = 1'b1;
                    rdata     = req_word ? sram_rdata[63:32] : sram_rdata[31:0];
                    fill_en   = 1'b1;
                    touch_en  = 1'b1;
                    touch_way = victim;
                    touch_idx = req_idx;
                end
            end
            WR_WAIT: begin
                ready = sram_ready;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
        freeze = (MEM_R_EN | MEM_W_EN) & ~ready;
    end

    // Request FSM with registered SRAM handshake and request capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            sram_address   <= '0;
            sram_wdata     <= '0;
            SRAM_mem_read  <= 1'b0;
            SRAM_mem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MEM_R_EN) begin
                        if (!hit) begin
                            sram_address  <= address;
                            SRAM_mem_read <= 1'b1;
                            state         <= RD_WAIT;
                        end
                    end else if (MEM_W_EN) begin
                        sram_address   <= address;
                        sram_wdata     <= wdata;
                        SRAM_mem_write <= 1'b1;
                        state          <= WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (sram_ready) begin
                        SRAM_mem_read <= 1'b0;
                        state         <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (sram_ready) begin
                        SRAM_mem_write <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Valid bits and per-set LRU ages; touched way goes to age 0, younger ways age by one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                valid[w] <= '0;
                for (int unsigned s = 0; s < SETS; s++) begin
                    age[w][s] <= AGE_BITS'(w);
                end
            end
        end else begin
            if (fill_en) begin
                valid[victim][req_idx] <= 1'b1;
            end
            if (touch_en) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (WAY_BITS'(w) == touch_way) begin
                        age[w][touch_idx] <= '0;
                    end else if (age[w][touch_idx] < age[touch_way][touch_idx]) begin
                        age[w][touch_idx] <= age[w][touch_idx] + 1'b1;
                    end
                end
            end
        end
    end

    // Line storage: fill on read-miss completion, word update on store hit
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_mem[victim][req_idx] <= sram_rdata;
            tag_mem[victim][req_idx]  <= req_tag;
        end else if (store_hit) begin
            if (cur_word) begin
                data_mem[hit_way][cur_idx][63:32] <= wdata;
            end else begin
                data_mem[hit_way][cur_idx][31:0] <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed testbench for set_assoc_cache: a 2-way and a 4-way instance share
// stimulus; sel4 routes requests and observation to one of them at a time.
module tb_set_assoc_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        r_en;
    logic        w_en;
    logic        sram_ready;
    logic [63:0] sram_rdata;
    logic        sel4;

    logic        r2, w2, sr2, r4, w4, sr4;
    logic [31:0] rdata2, rdata4, saddr2, saddr4, swdata2, swdata4;
    logic        ready2, ready4, freeze2, freeze4, rd2, rd4, wr2, wr4;

    logic [31:0] o_rdata, o_saddr, o_swdata;
    logic        o_ready, o_freeze, o_read, o_write;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign r2  = r_en & ~sel4;
    assign w2  = w_en & ~sel4;
    assign sr2 = sram_ready & ~sel4;
    assign r4  = r_en & sel4;
    assign w4  = w_en & sel4;
    assign sr4 = sram_ready & sel4;

    assign o_rdata  = sel4 ? rdata4  : rdata2;
    assign o_ready  = sel4 ? ready4  : ready2;
    assign o_freeze = sel4 ? freeze4 : freeze2;
    assign o_read   = sel4 ? rd4     : rd2;
    assign o_write  = sel4 ? wr4     : wr2;
    assign o_saddr  = sel4 ? saddr4  : saddr2;
    assign o_swdata = sel4 ? swdata4 : swdata2;

    set_assoc_cache #(.WAYS(2), .SET_BITS(6), .TAG_BITS(9)) dut2 (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .MEM_R_EN(r2), .MEM_W_EN(w2), .rdata(rdata2), .ready(ready2), .freeze(freeze2),
        .sram_address(saddr2), .sram_wdata(swdata2), .SRAM_mem_read(rd2),
        .SRAM_mem_write(wr2), .sram_ready(sr2), .sram_rdata(sram_rdata)
    );

    set_assoc_cache #(.WAYS(4), .SET_BITS(6), .TAG_BITS(9)) dut4 (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .MEM_R_EN(r4), .MEM_W_EN(w4), .rdata(rdata4), .ready(ready4), .freeze(freeze4),
        .sram_address(saddr4), .sram_wdata(swdata4), .SRAM_mem_read(rd4),
        .SRAM_mem_write(wr4), .sram_ready(sr4), .sram_rdata(sram_rdata)
    );

    function automatic logic [63:0] line_of(input logic [31:0] tag);
        return {32'hA000_0000 | tag, 32'hB000_0000 | tag};
    endfunction

    // Load request starting at posedge+1; on a miss answers with 'line' after 'lat' cycles.
    // ok collects the handshake/freeze expectations of every intermediate cycle.
    task automatic do_load(input logic [31:0] a, input logic [63:0] line, input int lat,
                           output logic was_hit, output logic [31:0] data, output logic ok);
        address = a; r_en = 1'b1; w_en = 1'b0;
        #4;
        ok = 1'b1;
        data = o_rdata;
        was_hit = (o_ready === 1'b1);
        if (!was_hit) begin
            ok = (o_freeze === 1'b1) && (o_read === 1'b0);
            for (int i = 1; i <= lat; i++) begin
                @(posedge clk); #1;
                if (i == lat) begin sram_ready = 1'b1; sram_rdata = line; end
                #4;
                if (i < lat)
                    ok = ok && (o_read === 1'b1) && (o_ready === 1'b0) && (o_freeze === 1'b1);
                else begin
                    ok = ok && (o_read === 1'b1) && (o_ready === 1'b1) && (o_freeze === 1'b0);
                    data = o_rdata;
                end
            end
        end
        @(posedge clk); #1;
        r_en = 1'b0; sram_ready = 1'b0;
    endtask

    // Store request; SRAM write acknowledged after 'lat' cycles.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int lat,
                            output logic ok);
        address = a; wdata = d; w_en = 1'b1; r_en = 1'b0;
        #4;
        ok = (o_freeze === 1'b1) && (o_write === 1'b0) && (o_ready === 1'b0);
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk); #1;
            if (i == lat) sram_ready = 1'b1;
            #4;
            if (i < lat)
                ok = ok && (o_write === 1'b1) && (o_ready === 1'b0) && (o_freeze === 1'b1);
            else
                ok = ok && (o_write === 1'b1) && (o_ready === 1'b1) && (o_freeze === 1'b0);
        end
        @(posedge clk); #1;
        w_en = 1'b0; sram_ready = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", o_ready); end
        vectors++; if (o_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", o_rdata); end
        vectors++; if (o_freeze !== 1'b0) begin miscompares++; $display("FAIL reset_freeze: got %b want 0", o_freeze); end
        vectors++; if ({o_read, o_write} !== 2'b00) begin miscompares++; $display("FAIL reset_sram_req: got %b want 00", {o_read, o_write}); end
        vectors++; if ({o_saddr, o_swdata} !== 64'h0) begin miscompares++; $display("FAIL reset_sram_regs: got %h want 0", {o_saddr, o_swdata}); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_read_miss_fill;
        logic h, ok; logic [31:0] d;
        do_load(32'h0000_0005, 64'hAAAA_0001_BBBB_0002, 3, h, d, ok);
        vectors++; if (h !== 1'b0) begin miscompares++; $display("FAIL rmf_first_hit: got %b want 0", h); end
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rmf_handshake: got %b want 1", ok); end
        vectors++; if (d !== 32'hAAAA_0001) begin miscompares++; $display("FAIL rmf_fill_data: got %h want aaaa0001", d); end
        vectors++; if (o_saddr !== 32'h5) begin miscompares++; $display("FAIL rmf_sram_addr: got %h want 5", o_saddr); end
        do_load(32'h0000_0005, 64'h0, 3, h, d, ok);
        vectors++; if (h !== 1'b1) begin miscompares++; $display("FAIL rmf_reload_hit: got %b want 1", h); end
        vectors++; if (d !== 32'hAAAA_0001) begin miscompares++; $display("FAIL rmf_reload_data: got %h want aaaa0001", d); end
        do_load(32'h0000_0004, 64'h0, 3, h, d, ok);
        vectors++; if ({h, d} !== {1'b1, 32'hBBBB_0002}) begin miscompares++; $display("FAIL rmf_word0: got %b/%h want 1/bbbb0002", h, d); end
    endtask

    task automatic test_lru_2way;
        logic h, ok; logic [31:0] d;
        do_load(32'h080, line_of(1), 2, h, d, ok);
        vectors++; if ({h, ok, d} !== {1'b0, 1'b1, 32'hB000_0001}) begin miscompares++; $display("FAIL lru2_fill_t1: got %b/%b/%h want 0/1/b0000001", h, ok, d); end
        do_load(32'h100, line_of(2), 2, h, d, ok);
        vectors++; if ({h, ok, d} !== {1'b0, 1'b1, 32'hB000_0002}) begin miscompares++; $display("FAIL lru2_fill_t2: got %b/%b/%h want 0/1/b0000002", h, ok, d); end
        do_load(32'h080, 64'h0, 2, h, d, ok);
        vectors++; if ({h, d} !== {1'b1, 32'hB000_0001}) begin miscompares++; $display("FAIL lru2_hit_t1: got %b/%h want 1/b0000001", h, d); end
        do_load(32'h180, line_of(3), 2, h, d, ok);
        vectors++; if ({h, ok, d} !== {1'b0, 1'b1, 32'hB000_0003}) begin miscompares++; $display("FAIL lru2_fill_t3: got %b/%b/%h want 0/1/b0000003", h, ok, d); end
        do_load(32'h080, 64'h0, 2, h, d, ok);
        vectors++; if ({h, d} !== {1'b1, 32'hB000_0001}) begin miscompares++; $display("FAIL lru2_keep_t1: got %b/%h want 1/b0000001", h, d); end
        do_load(32'h100, line_of(2), 2, h, d, ok);
        vectors++; if (h !== 1'b0) begin miscompares++; $display("FAIL lru2_evict_t2: got hit %b want 0", h); end
    endtask

    task automatic test_lru_4way;
        logic h, ok; logic [31:0] d;
        logic [31:0] keep [4];
        keep[0] = 1; keep[1] = 4; keep[2] = 5; keep[3] = 6;
        sel4 = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            do_load((32'(t) << 7) | 32'h2, line_of(32'(t)), 2, h, d, ok);
            vectors++; if ({h, ok, d} !== {1'b0, 1'b1, 32'hB000_0000 | 32'(t)}) begin miscompares++; $display("FAIL lru4_fill_t%0d: got %b/%b/%h", t, h, ok, d); end
        end
        do_load(32'h082, 64'h0, 2, h, d, ok);
        vectors++; if ({h, d} !== {1'b1, 32'hB000_0001}) begin miscompares++; $display("FAIL lru4_hit_t1: got %b/%h want 1/b0000001", h, d); end
        do_load(32'h282, line_of(5), 2, h, d, ok);
        vectors++; if ({h, d} !== {1'b0, 32'hB000_0005}) begin miscompares++; $display("FAIL lru4_fill_t5: got %b/%h want 0/b0000005", h, d); end
        do_load(32'h302, line_of(6), 2, h, d, ok);
        vectors++; if ({h, d} !== {1'b0, 32'hB000_0006}) begin miscompares++; $display("FAIL lru4_fill_t6: got %b/%h want 0/b0000006", h, d); end
        for (int k = 0; k < 4; k++) begin
            do_load((keep[k] << 7) | 32'h2, 64'h0, 2, h, d, ok);
            vectors++; if ({h, d} !== {1'b1, 32'hB000_0000 | keep[k]}) begin miscompares++; $display("FAIL lru4_resident_t%0d: got %b/%h want 1", keep[k], h, d); end
        end
        do_load(32'h102, line_of(2), 2, h, d, ok);
        vectors++; if (h !== 1'b0) begin miscompares++; $display("FAIL lru4_evicted_t2: got hit %b want 0", h); end
        do_load(32'h182, line_of(3), 2, h, d, ok);
        vectors++; if (h !== 1'b0) begin miscompares++; $display("FAIL lru4_evicted_t3: got hit %b want 0", h); end
        sel4 = 1'b0;
    endtask

    task automatic test_store;
        logic h, ok; logic [31:0] d;
        do_store(32'h0000_0005, 32'h1234_5678, 3, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL st_hit_handshake: got %b want 1", ok); end
        vectors++; if ({o_saddr, o_swdata} !== {32'h5, 32'h1234_5678}) begin miscompares++; $display("FAIL st_sram_regs: got %h/%h want 5/12345678", o_saddr, o_swdata); end
        do_load(32'h0000_0005, 64'h0, 2, h, d, ok);
        vectors++; if ({h, d} !== {1'b1, 32'h1234_5678}) begin miscompares++; $display("FAIL st_updated_word: got %b/%h want 1/12345678", h, d); end
        do_load(32'h0000_0004, 64'h0, 2, h, d, ok);
        vectors++; if ({h, d} !== {1'b1, 32'hBBBB_0002}) begin miscompares++; $display("FAIL st_other_word: got %b/%h want 1/bbbb0002", h, d); end
        do_store(32'h0000_0200, 32'hCAFE_F00D, 2, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL st_miss_handshake: got %b want 1", ok); end
        do_load(32'h0000_0200, line_of(4), 2, h, d, ok);
        vectors++; if ({h, d} !== {1'b0, 32'hB000_0004}) begin miscompares++; $display("FAIL st_no_allocate: got %b/%h want 0/b0000004", h, d); end
    endtask

    task automatic test_rw_conflict;
        logic h, ok; logic [31:0] d;
        address = 32'h5; wdata = 32'hDEAD_BEEF; r_en = 1'b1; w_en = 1'b1;
        #4;
        vectors++; if ({o_ready, o_rdata} !== {1'b1, 32'h1234_5678}) begin miscompares++; $display("FAIL rw_as_load: got %b/%h want 1/12345678", o_ready, o_rdata); end
        @(posedge clk); #1;
        r_en = 1'b0; w_en = 1'b0;
        #4;
        vectors++; if ({o_read, o_write} !== 2'b00) begin miscompares++; $display("FAIL rw_no_sram: got %b want 00", {o_read, o_write}); end
        @(posedge clk); #1;
        do_load(32'h5, 64'h0, 2, h, d, ok);
        vectors++; if ({h, d} !== {1'b1, 32'h1234_5678}) begin miscompares++; $display("FAIL rw_no_store: got %b/%h want 1/12345678", h, d); end
    endtask

    task automatic test_reset_mid;
        logic h, ok; logic [31:0] d;
        address = 32'h300; r_en = 1'b1;
        @(posedge clk); #1; #4;
        vectors++; if (o_read !== 1'b1) begin miscompares++; $display("FAIL rm_read_up: got %b want 1", o_read); end
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        vectors++; if ({o_read, o_ready} !== 2'b00) begin miscompares++; $display("FAIL rm_read_drop: got %b want 00", {o_read, o_ready}); end
        vectors++; if (o_saddr !== 32'h0) begin miscompares++; $display("FAIL rm_addr_clear: got %h want 0", o_saddr); end
        r_en = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        do_load(32'h5, 64'h1111_2222_3333_4444, 2, h, d, ok);
        vectors++; if ({h, ok, d} !== {1'b0, 1'b1, 32'h1111_2222}) begin miscompares++; $display("FAIL rm_invalidated: got %b/%b/%h want 0/1/11112222", h, ok, d); end
    endtask

    task automatic test_idle_sram_ready;
        logic h, ok; logic [31:0] d;
        sram_ready = 1'b1; sram_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #4;
        vectors++; if ({o_ready, o_freeze, o_read} !== 3'b000) begin miscompares++; $display("FAIL idle_pulse: got %b want 000", {o_ready, o_freeze, o_read}); end
        @(posedge clk); #1;
        sram_ready = 1'b0;
        #4;
        vectors++; if ({o_read, o_write, o_ready} !== 3'b000) begin miscompares++; $display("FAIL idle_after: got %b want 000", {o_read, o_write, o_ready}); end
        @(posedge clk); #1;
        do_load(32'h4, 64'h0, 2, h, d, ok);
        vectors++; if ({h, d} !== {1'b1, 32'h3333_4444}) begin miscompares++; $display("FAIL idle_line_intact: got %b/%h want 1/33334444", h, d); end
    endtask

    task automatic test_back_to_back;
        logic h, ok; logic [31:0] d;
        address = 32'h7; r_en = 1'b1; sram_ready = 1'b1; sram_rdata = 64'h0;
        #4;
        vectors++; if ({o_ready, o_freeze} !== 2'b01) begin miscompares++; $display("FAIL b2b_req_cycle: got %b want 01", {o_ready, o_freeze}); end
        @(posedge clk); #1;
        sram_ready = 1'b0;
        #4;
        vectors++; if ({o_read, o_ready, o_freeze} !== 3'b101) begin miscompares++; $display("FAIL b2b_wait: got %b want 101", {o_read, o_ready, o_freeze}); end
        @(posedge clk); #1;
        sram_ready = 1'b1; sram_rdata = 64'h5555_6666_7777_8888;
        #4;
        vectors++; if ({o_ready, o_rdata} !== {1'b1, 32'h5555_6666}) begin miscompares++; $display("FAIL b2b_done: got %b/%h want 1/55556666", o_ready, o_rdata); end
        @(posedge clk); #1;
        sram_ready = 1'b0; r_en = 1'b0;
        do_load(32'h6, 64'h0, 2, h, d, ok);
        vectors++; if ({h, d} !== {1'b1, 32'h7777_8888}) begin miscompares++; $display("FAIL b2b_next_hit: got %b/%h want 1/77778888", h, d); end
    endtask

    initial begin
        rst = 1'b0; address = '0; wdata = '0; r_en = 1'b0; w_en = 1'b0;
        sram_ready = 1'b0; sram_rdata = '0; sel4 = 1'b0;
        test_reset;
        test_read_miss_fill;
        test_lru_2way;
        test_lru_4way;
        test_store;
        test_rw_conflict;
        test_reset_mid;
        test_idle_sram_ready;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
